// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: FSM state encoding
// and the NOP word loaded into the instruction register at reset.
package cpu_bus_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } seq_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/cpu_bus_sequencer_bus_watchdog.sv
// Counts cycles an outstanding bus request has waited without ack;
// flags expiry on the cycle the wait reaches TIMEOUT. TIMEOUT=0 disables it.
module bus_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIM_I);
    localparam logic EN = (TIMEOUT > 0);

    logic [CW-1:0] cnt;
    logic          at_limit;

    assign at_limit = (cnt == LIMIT);
    assign expired  = EN && active && !ack && at_limit;

    // A dropped request (state change) or an ack restarts the count
    always_ff @(posedge clk) begin
        if (rst || !active || ack) begin
            cnt <= '0;
        end else if (!at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer: owns PC and IR, drives
// ROM and data memory over req/ack and traps on a stuck bus access.
module cpu_bus_sequencer
    import cpu_bus_sequencer_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int          TIMEOUT      = 256,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rom_req,
    output logic [XLEN-1:0]  rom_addr,
    input  logic             rom_ack,
    input  logic [31:0]      rom_rdata,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  dp_next_addr,
    input  logic             dp_mem_read,
    input  logic             dp_mem_write,
    input  logic [XLEN-1:0]  dp_addr,
    input  logic [XLEN-1:0]  dp_wdata,
    input  logic [3:0]       dp_bytes,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [3:0]       mem_bytes,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [XLEN-1:0]  load_data,
    output logic             reg_we,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap
);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [XLEN-1:0] next_pc;
    logic            is_mem;
    logic            wd_active;
    logic            wd_ack;
    logic            wd_expired;
    logic            fetch_done;
    logic            mem_latch;
    logic            load_done;

    assign is_mem   = dp_mem_read | dp_mem_write;
    assign rom_addr = pc;
    assign trap     = (state_q == ST_TRAP);

    assign wd_active = rom_req | mem_req;
    assign wd_ack    = (rom_req & rom_ack) | (mem_req & mem_ack);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        rom_req = 1'b0;
        mem_req = 1'b0;
        reg_we  = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack)         state_d = ST_EXEC;
                else if (wd_expired) state_d = ST_TRAP;
            end
            ST_EXEC: begin
                if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (mem_we) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
        // Reset wins over any ack arriving in the same cycle
        if (rst) begin
            rom_req = 1'b0;
            mem_req = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    assign fetch_done = rom_req & rom_ack;
    assign mem_latch  = (state_q == ST_EXEC) & is_mem;
    assign load_done  = mem_req & mem_ack & ~mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc          <= RESET_VECTOR;
            instr       <= NOP;
            next_pc     <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_bytes   <= '0;
            load_data   <= '0;
            retired_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (fetch_done) instr <= rom_rdata;
            if (mem_latch) begin
                mem_we    <= dp_mem_write;
                mem_addr  <= dp_addr;
                mem_wdata <= dp_wdata;
                mem_bytes <= dp_bytes;
                next_pc   <= dp_next_addr;
            end
            if (load_done) load_data <= mem_rdata;
            if (retire) begin
                pc          <= (state_q == ST_EXEC) ? dp_next_addr : next_pc;
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: fetch stream, ROM waits,
// load/store handshakes, watchdog trap and reset during an access.
module tb_cpu_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] dp_next_addr;
    logic        dp_mem_read;
    logic        dp_mem_write;
    logic [31:0] dp_addr;
    logic [31:0] dp_wdata;
    logic [3:0]  dp_bytes;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bytes;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        reg_we;
    logic        retire;
    logic [31:0] retired_cnt;
    logic        trap;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    cpu_bus_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .TIMEOUT      (8),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_rdata    (rom_rdata),
        .instr        (instr),
        .pc           (pc),
        .dp_next_addr (dp_next_addr),
        .dp_mem_read  (dp_mem_read),
        .dp_mem_write (dp_mem_write),
        .dp_addr      (dp_addr),
        .dp_wdata     (dp_wdata),
        .dp_bytes     (dp_bytes),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_bytes    (mem_bytes),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .load_data    (load_data),
        .reg_we       (reg_we),
        .retire       (retire),
        .retired_cnt  (retired_cnt),
        .trap         (trap)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        rom_ack   = 1'b1;
        rom_rdata = w;
        tick();
        rom_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rom_ack = 0; rom_rdata = 0;
        dp_next_addr = 0; dp_mem_read = 0; dp_mem_write = 0;
        dp_addr = 0; dp_wdata = 0; dp_bytes = 0;
        mem_ack = 0; mem_rdata = 0;

        // 1: reset state and zero-wait ALU stream
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h13);
        check("rst_rom_req", rom_req, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_trap", trap, 0);
        check("rst_cnt", retired_cnt, 0);
        check("rst_load", load_data, 0);
        check("rst_regwe", reg_we, 0);
        for (int i = 0; i < 3; i++) begin
            rom_ack   = 1'b1;
            rom_rdata = 32'h0010_0093 + i;
            #1;
            check("alu_rom_addr", rom_addr, 4 * i);
            check("alu_fetch_noret", retire, 0);
            tick();
            rom_ack      = 1'b0;
            dp_next_addr = 4 * (i + 1);
            #1;
            check("alu_instr", instr, 32'h0010_0093 + i);
            check("alu_retire", retire, 1);
            check("alu_regwe", reg_we, 1);
            check("alu_exec_noreq", rom_req, 0);
            tick();
            #1;
            check("alu_pc", pc, 4 * (i + 1));
            check("alu_cnt", retired_cnt, i + 1);
        end

        // 2: ROM ack after 3 wait cycles
        rom_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rwait_req", rom_req, 1);
            check("rwait_addr", rom_addr, 32'hC);
            check("rwait_noret", retire, 0);
            tick();
        end
        rom_ack   = 1'b1;
        rom_rdata = 32'h0020_0113;
        #1;
        check("rwait_ack_req", rom_req, 1);
        check("rwait_ack_addr", rom_addr, 32'hC);
        tick();
        rom_ack      = 1'b0;
        dp_next_addr = 32'h10;
        #1;
        check("rwait_instr", instr, 32'h0020_0113);
        check("rwait_retire", retire, 1);
        tick();
        #1;
        check("rwait_pc", pc, 32'h10);
        check("rwait_cnt", retired_cnt, 4);

        // 3: load with 2 wait cycles
        cyc = 0;
        fetch(32'h0000_2083);
        cyc++;
        dp_mem_read  = 1'b1;
        dp_addr      = 32'h200;
        dp_next_addr = 32'h14;
        dp_bytes     = 4'hF;
        #1;
        check("lw_exec_noret", retire, 0);
        check("lw_exec_noregwe", reg_we, 0);
        tick();
        cyc++;
        dp_mem_read = 1'b0;
        dp_addr     = 32'hBAD0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lw_wait_req", mem_req, 1);
            check("lw_wait_addr", mem_addr, 32'h200);
            check("lw_wait_we", mem_we, 0);
            check("lw_wait_regwe", reg_we, 0);
            tick();
            cyc++;
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_ack_noret", retire, 0);
        check("lw_ack_noregwe", reg_we, 0);
        tick();
        cyc++;
        mem_ack = 1'b0;
        #1;
        check("lw_wb_data", load_data, 32'hDEAD_BEEF);
        check("lw_wb_regwe", reg_we, 1);
        check("lw_wb_retire", retire, 1);
        check("lw_wb_noreq", mem_req, 0);
        tick();
        cyc++;
        #1;
        check("lw_cycles", cyc, 6);
        check("lw_pc", pc, 32'h14);
        check("lw_refetch", rom_req, 1);
        check("lw_cnt", retired_cnt, 5);

        // 4: store, one wait cycle
        fetch(32'h0020_1023);
        dp_mem_write = 1'b1;
        dp_addr      = 32'h100;
        dp_wdata     = 32'hCAFE_0001;
        dp_bytes     = 4'b0011;
        dp_next_addr = 32'h18;
        tick();
        dp_mem_write = 1'b0;
        dp_addr      = 0;
        dp_bytes     = 0;
        #1;
        check("sw_we", mem_we, 1);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_bytes", mem_bytes, 4'b0011);
        check("sw_wdata", mem_wdata, 32'hCAFE_0001);
        check("sw_wait_noret", retire, 0);
        tick();
        mem_ack = 1'b1;
        #1;
        check("sw_ack_addr", mem_addr, 32'h100);
        check("sw_ack_retire", retire, 1);
        check("sw_ack_noregwe", reg_we, 0);
        tick();
        mem_ack = 1'b0;
        #1;
        check("sw_pc", pc, 32'h18);
        check("sw_noreq", mem_req, 0);
        check("sw_cnt", retired_cnt, 6);

        // 5: load that never completes -> trap after 8 req cycles
        fetch(32'h0000_2183);
        dp_mem_read  = 1'b1;
        dp_addr      = 32'h400;
        dp_next_addr = 32'h1C;
        tick();
        dp_mem_read = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("to_req", mem_req, 1);
            check("to_notrap", trap, 0);
            tick();
        end
        #1;
        check("to_trap", trap, 1);
        check("to_req_drop", mem_req, 0);
        check("to_rom_drop", rom_req, 0);
        check("to_pc_frozen", pc, 32'h18);
        rom_ack = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("to_ack_noret", retire, 0);
        check("to_ack_noregwe", reg_we, 0);
        tick();
        tick();
        rom_ack = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("to_still_trap", trap, 1);
        check("to_pc_hold", pc, 32'h18);
        check("to_cnt_hold", retired_cnt, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("to_rst_pc", pc, 32'h0);
        check("to_rst_trap", trap, 0);
        check("to_rst_instr", instr, 32'h13);
        check("to_rst_req", rom_req, 1);
        check("to_rst_cnt", retired_cnt, 0);

        // 6: reset during MEM with ack in the same cycle
        fetch(32'h0000_2203);
        dp_mem_read  = 1'b1;
        dp_addr      = 32'h300;
        dp_next_addr = 32'h4;
        tick();
        dp_mem_read = 1'b0;
        #1;
        check("rm_req", mem_req, 1);
        tick();
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        check("rm_noret", retire, 0);
        check("rm_noregwe", reg_we, 0);
        tick();
        rst     = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("rm_pc", pc, 32'h0);
        check("rm_rom_addr", rom_addr, 32'h0);
        check("rm_fetch", rom_req, 1);
        check("rm_noreq", mem_req, 0);
        check("rm_cnt", retired_cnt, 0);
        check("rm_load", load_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
